snoop_bus_arbiter: RTL



---
 rtl/snoop_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/snoop_bus_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping bus: sequencer states, bus op encoding
// and the default processor count. Used by the arbiter, processor and bus blocks.
package snoop_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      SNOOP = 3'd2,
      MEM   = 3'd3,
      C2C   = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic OP_READ  = 1'b0;  // read miss
   localparam logic OP_WRITE = 1'b1;  // write miss / invalidate

   localparam int N_CPU_DEFAULT = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: starting just after last_owner and
// wrapping around, returns the first requesting index. valid is low when
// nobody requests, in which case winner is 0 and must be ignored.
module rr_arbiter
   import snoop_pkg::*;
#(
   parameter int N_CPU = N_CPU_DEFAULT
) (
   input  logic [N_CPU-1:0] req,
   input  logic [1:0]       last_owner,
   output logic [1:0]       winner,
   output logic             valid
);

   logic found;

   // Two ascending scans: indices above last_owner first, then the wrap-around
   // part up to and including last_owner (lowest priority).
   always_comb begin
      winner = 2'd0;
      found  = 1'b0;
      for (int j = 0; j < N_CPU; j++) begin
         if (!found && req[j] && (2'(j) > last_owner)) begin
            winner = 2'(j);
            found  = 1'b1;
         end
      end
      for (int j = 0; j < N_CPU; j++) begin
         if (!found && req[j] && (2'(j) <= last_owner)) begin
            winner = 2'(j);
            found  = 1'b1;
         end
      end
      valid = |req;
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus sequencer. Grants the bus round-robin to one CPU, lets the
// other caches snoop, then either runs a memory access or a cache-to-cache
// transfer (memory aborted), and ends with a one-cycle done pulse to the owner.
//
// req/gnt handshake: req is a level that is only looked at while the bus is
// idle; the cycle after a sampled req the winner sees gnt, and gnt stays high
// until the end of its done cycle. A req that disappears before it is
// sampled is never served; once granted, the transaction always completes
// regardless of req. Every output is decoded from registered state.
module snoop_bus_arbiter
   import snoop_pkg::*;
#(
   parameter int N_CPU   = N_CPU_DEFAULT,
   parameter int MEM_LAT = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_CPU-1:0] req,
   input  logic [N_CPU-1:0] req_op,
   input  logic [N_CPU-1:0] snoop_hit,
   output logic [N_CPU-1:0] gnt,
   output logic [N_CPU-1:0] snoop_en,
   output logic             bus_op,
   output logic [1:0]       owner,
   output logic             mem_start,
   output logic             mem_abort,
   output logic [N_CPU-1:0] done,
   output logic             busy
);

   localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

   state_t           state_q, state_d;
   logic [1:0]       owner_q;
   logic [1:0]       last_owner_q;
   logic             bus_op_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [1:0]       pick;
   logic             pick_valid;
   logic             pick_op;
   logic [N_CPU-1:0] owner_mask;
   logic             hit;

   rr_arbiter #(.N_CPU(N_CPU)) u_rr (
      .req        (req),
      .last_owner (last_owner_q),
      .winner     (pick),
      .valid      (pick_valid)
   );

   // Owner one-hot mask, op bit of the candidate, and the snoop hit from the
   // non-owner caches only (the owner's own hit line is meaningless here).
   always_comb begin
      owner_mask = '0;
      pick_op    = OP_READ;
      for (int j = 0; j < N_CPU; j++) begin
         owner_mask[j] = (owner_q == 2'(j));
         if (pick == 2'(j)) begin
            pick_op = req_op[j];
         end
      end
      hit = |(snoop_hit & ~owner_mask);
   end

   // State register plus the transaction registers (owner, op, latency
   // counter, round-robin pointer). Reset puts priority back on CPU0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 2'd0;
         last_owner_q <= 2'(N_CPU - 1);
         bus_op_q     <= OP_READ;
         cnt_q        <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == IDLE && pick_valid) begin
            owner_q  <= pick;
            bus_op_q <= pick_op;
         end
         if (state_q == DONE) begin
            last_owner_q <= owner_q;
         end
      end
   end

   // Next-state and counter logic for the bus transaction sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:  if (pick_valid) state_d = GRANT;
         GRANT: state_d = SNOOP;
         SNOOP: begin
            if (hit) begin
               state_d = C2C;
            end else begin
               state_d = MEM;
               cnt_d   = CNT_LOAD;
            end
         end
         MEM: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         C2C:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the registered state; the first MEM cycle is the one
   // where the counter still holds its load value.
   always_comb begin
      gnt       = '0;
      snoop_en  = '0;
      mem_start = 1'b0;
      mem_abort = 1'b0;
      done      = '0;
      busy      = (state_q != IDLE);
      case (state_q)
         GRANT, SNOOP: begin
            gnt      = owner_mask;
            snoop_en = ~owner_mask;
         end
         MEM: begin
            gnt       = owner_mask;
            mem_start = (cnt_q == CNT_LOAD);
         end
         C2C: begin
            gnt       = owner_mask;
            mem_abort = 1'b1;
         end
         DONE: begin
            gnt  = owner_mask;
            done = owner_mask;
         end
         default: ;
      endcase
   end

   assign owner  = owner_q;
   assign bus_op = bus_op_q;

endmodule
